// File: rtl/regfile_pkg.sv
// Shared register-file constants and the sweep/run FSM state type.
package regfile_pkg;

   localparam int REG_DATA_W = 32;   // register width
   localparam int REG_ADDR_W = 5;    // register address width
   localparam int REG_NUM    = 32;   // architectural register count

   localparam logic [REG_DATA_W-1:0] ZERO_WORD = '0;

   // CLEAR: post-reset sweep zeroing one entry per cycle; RUN: file usable
   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } rf_state_t;

endpackage

// File: rtl/regfile.sv
// General-purpose register file: 2 combinational read ports, 1 synchronous
// write port, $0 hard-wired to zero. Storage is cleared by a post-reset sweep
// rather than a parallel reset so the array can map onto RAM-style logic.
module regfile
   import regfile_pkg::*;
#(
   parameter int DATA_W   = REG_DATA_W,
   parameter int ADDR_W   = REG_ADDR_W,
   parameter int NUM_REGS = REG_NUM
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   output logic              ready_o
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   rf_state_t         state;
   logic [ADDR_W-1:0] clr_cnt;
   logic [DATA_W-1:0] regs [NUM_REGS];   // entry 0 is never written

   // Sweep FSM: reset restarts the sweep at entry 1; RUN is absorbing until rst
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= ADDR_W'(1);
      end else if (state == CLEAR) begin
         clr_cnt <= clr_cnt + ADDR_W'(1);
         if (clr_cnt == LAST_IDX)
            state <= RUN;
      end
   end

   // Storage: sweep zeroing in CLEAR, architectural writes only in RUN
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR)
            regs[clr_cnt] <= ZERO_WORD;
         else if (we && (waddr != '0))
            regs[waddr] <= wdata;
      end
   end

   assign ready_o = (state == RUN);

   // Read port 1: gated by reset/ready/enable, $0 forced, same-cycle write bypass
   always_comb begin
      rdata1 = ZERO_WORD;
      if (rst || !ready_o)
         rdata1 = ZERO_WORD;
      else if (!re1)
         rdata1 = ZERO_WORD;
      else if (raddr1 == '0)
         rdata1 = ZERO_WORD;
      else if (we && (waddr == raddr1))
         rdata1 = wdata;
      else
         rdata1 = regs[raddr1];
   end

   // Read port 2: identical to port 1
   always_comb begin
      rdata2 = ZERO_WORD;
      if (rst || !ready_o)
         rdata2 = ZERO_WORD;
      else if (!re2)
         rdata2 = ZERO_WORD;
      else if (raddr2 == '0)
         rdata2 = ZERO_WORD;
      else if (we && (waddr == raddr2))
         rdata2 = wdata;
      else
         rdata2 = regs[raddr2];
   end

endmodule
